// File: rtl/telemetry_framer_pkg.sv
// -----------------------------------------------------------------------------
// telemetry_framer_pkg
// Shared definitions for the telemetry framer: FSM state enumeration, the
// number of non-payload bytes in a frame and the default frame start byte.
// -----------------------------------------------------------------------------
package telemetry_framer_pkg;

  typedef enum int unsigned {
    ST_IDLE = 0,
    ST_SYNC = 1,
    ST_LEN  = 2,
    ST_LOAD = 3,
    ST_PAY  = 4,
    ST_CHK  = 5,
    ST_DONE = 6
  } state_t;

  // SYNC + LEN + CHK
  localparam int FRAME_OVERHEAD = 3;

  localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

endpackage

// File: rtl/telemetry_framer_if.sv
// -----------------------------------------------------------------------------
// telemetry_framer_if
// Groups the framer's handshake and FIFO-side signals.
//   start      : begin one frame (host -> framer)
//   word_data  : 32-bit payload word (host -> framer)
//   word_valid : word_data valid (host -> framer)
//   word_ready : framer accepts word this cycle (framer -> host)
//   tx_count   : TX FIFO byte count, only [7:0] meaningful (FIFO -> framer)
//   tx_wd      : FIFO write data {24'h0, byte} (framer -> FIFO)
//   tx_we      : FIFO write strobe (framer -> FIFO)
//   busy       : frame in progress (framer -> host)
//   done       : one-cycle pulse after the checksum byte (framer -> host)
// master = host/FIFO side, slave = framer side.
// -----------------------------------------------------------------------------
interface telemetry_framer_if;
  logic        start;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] tx_count;
  logic [31:0] tx_wd;
  logic        tx_we;
  logic        busy;
  logic        done;

  modport master (
    output start, word_data, word_valid, tx_count,
    input  word_ready, tx_wd, tx_we, busy, done
  );

  modport slave (
    input  start, word_data, word_valid, tx_count,
    output word_ready, tx_wd, tx_we, busy, done
  );
endinterface

// File: rtl/telemetry_framer.sv
// -----------------------------------------------------------------------------
// telemetry_framer
// Collects NWORDS 32-bit words over a valid/ready handshake and writes a
// byte-serial frame into the TX FIFO: SYNC, LEN (=4*NWORDS), payload bytes
// (least significant byte of each word first), CHK (8-bit sum of LEN and all
// payload bytes). Writes are throttled by the FIFO byte count so the FIFO
// never overflows.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : telemetry_framer_if.slave (handshake, FIFO write port, status)
// -----------------------------------------------------------------------------
module telemetry_framer
  import telemetry_framer_pkg::*;
#(
  parameter int         NWORDS = 4,
  parameter logic [7:0] SYNC   = DEFAULT_SYNC,
  parameter int         TX_CAP = 31
) (
  input  logic               clk,
  input  logic               rst,
  telemetry_framer_if.slave  bus
);

  localparam logic [7:0] LEN_BYTE  = 8'(4 * NWORDS);
  localparam logic [7:0] CAP_BYTE  = 8'(TX_CAP);
  localparam logic [5:0] LAST_WORD = 6'(NWORDS - 1);

  state_t      state, state_n;
  logic [7:0]  chk, chk_n;
  logic [5:0]  word_idx, word_idx_n;
  logic [1:0]  byte_idx, byte_idx_n;
  logic [31:0] shift, shift_n;

  logic        space;
  logic        tx_we_c;
  logic [7:0]  tx_byte;
  logic        word_ready_c;

  // Only the low byte of the FIFO count carries information.
  logic        unused_count_hi;
  assign unused_count_hi = ^bus.tx_count[31:8];

  // The FIFO count updates on the same edge as our write, so comparing the
  // current count against capacity is enough to allow back-to-back writes.
  assign space = (bus.tx_count[7:0] < CAP_BYTE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      chk      <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      shift    <= '0;
    end else begin
      state    <= state_n;
      chk      <= chk_n;
      word_idx <= word_idx_n;
      byte_idx <= byte_idx_n;
      shift    <= shift_n;
    end
  end

  // Emit states hold their byte on tx_wd and only advance on a cycle where
  // the write actually happens, so a full FIFO simply freezes the frame.
  always_comb begin
    state_n      = state;
    chk_n        = chk;
    word_idx_n   = word_idx;
    byte_idx_n   = byte_idx;
    shift_n      = shift;
    word_ready_c = 1'b0;
    tx_we_c      = 1'b0;
    tx_byte      = 8'h00;

    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_n    = ST_SYNC;
          chk_n      = '0;
          word_idx_n = '0;
        end
      end
      ST_SYNC: begin
        tx_byte = SYNC;
        tx_we_c = space;
        if (space) state_n = ST_LEN;
      end
      ST_LEN: begin
        tx_byte = LEN_BYTE;
        tx_we_c = space;
        if (space) begin
          chk_n   = LEN_BYTE;
          state_n = ST_LOAD;
        end
      end
      ST_LOAD: begin
        word_ready_c = 1'b1;
        if (bus.word_valid) begin
          shift_n    = bus.word_data;
          byte_idx_n = '0;
          state_n    = ST_PAY;
        end
      end
      ST_PAY: begin
        tx_byte = shift[7:0];
        tx_we_c = space;
        if (space) begin
          chk_n      = chk + shift[7:0];
          shift_n    = {8'h00, shift[31:8]};
          byte_idx_n = byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            if (word_idx == LAST_WORD) begin
              state_n = ST_CHK;
            end else begin
              word_idx_n = word_idx + 6'd1;
              state_n    = ST_LOAD;
            end
          end
        end
      end
      ST_CHK: begin
        tx_byte = chk;
        tx_we_c = space;
        if (space) state_n = ST_DONE;
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign bus.word_ready = word_ready_c;
  assign bus.tx_we      = tx_we_c;
  assign bus.tx_wd      = {24'h000000, tx_byte};
  assign bus.busy       = (state != ST_IDLE);
  assign bus.done       = (state == ST_DONE);

endmodule
